// File: rtl/eq_pkg.sv
// Shared definitions for the equalizer pot scanner: slot order, A2D channel map,
// scheduler state encoding and the A2D command word format.
package eq_pkg;

    localparam int POT_W  = 12;
    localparam int N_SLOT = 6;

    typedef enum logic [2:0] {
        SLOT_LP, SLOT_B1, SLOT_B2, SLOT_B3, SLOT_HP, SLOT_VOL
    } slot_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD_XFER, ST_GAP1, ST_READ_XFER, ST_STORE, ST_GAP2
    } state_e;

    // A2D input channel wired to each slot, indexed by slot_e
    localparam logic [2:0] CH_MAP [N_SLOT] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

    function automatic logic [15:0] a2d_cmd(input logic [2:0] ch);
        return {2'b00, ch, 11'b0};
    endfunction

endpackage

// File: rtl/spi_mstr16.sv
// 16-bit full-duplex SPI master: SCLK idles high, MOSI driven on SCLK fall,
// MISO sampled on SCLK rise, MSB first. o_done is high on the last busy cycle.
module spi_mstr16 #(
    parameter int SCLK_DIV = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_wrt,
    input  logic [15:0] i_cmd,
    input  logic        i_miso,
    output logic        o_ss_n,
    output logic        o_sclk,
    output logic        o_mosi,
    output logic        o_done,
    output logic [15:0] o_rd_data
);

    localparam int HALF = SCLK_DIV / 2;
    localparam int HW   = $clog2(HALF + 1);

    logic          r_busy;
    logic [HW-1:0] r_hcnt;
    logic [5:0]    r_half;
    logic [15:0]   r_tx;
    logic [15:0]   r_rx;
    logic          r_ss_n;
    logic          r_sclk;
    logic          r_mosi;
    logic          w_hend;
    logic [5:0]    w_half_nxt;

    assign w_hend     = (r_hcnt == HW'(HALF - 1));
    assign w_half_nxt = r_half + 6'd1;

    // Half-period 0 is SS_n setup, odd halves 1..31 start with SCLK fall,
    // even halves 2..32 with SCLK rise, 33 is SS_n hold, end of 33 completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_hcnt <= '0;
            r_half <= '0;
            r_tx   <= '0;
            r_rx   <= '0;
            r_ss_n <= 1'b1;
            r_sclk <= 1'b1;
            r_mosi <= 1'b0;
        end else if (!r_busy) begin
            if (i_wrt) begin
                r_busy <= 1'b1;
                r_hcnt <= '0;
                r_half <= '0;
                r_tx   <= i_cmd;
                r_ss_n <= 1'b0;
            end
        end else begin
            r_hcnt <= w_hend ? '0 : r_hcnt + 1'b1;
            if (w_hend) begin
                r_half <= w_half_nxt;
                if (w_half_nxt <= 6'd32) begin
                    if (w_half_nxt[0]) begin
                        r_sclk <= 1'b0;
                        r_mosi <= r_tx[15];
                        r_tx   <= {r_tx[14:0], 1'b0};
                    end else begin
                        r_sclk <= 1'b1;
                        r_rx   <= {r_rx[14:0], i_miso};
                    end
                end else if (w_half_nxt == 6'd33) begin
                    r_ss_n <= 1'b1;
                    r_mosi <= 1'b0;
                end else begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign o_done    = r_busy && w_hend && (r_half == 6'd33);
    assign o_ss_n    = r_ss_n;
    assign o_sclk    = r_sclk;
    assign o_mosi    = r_mosi;
    assign o_rd_data = r_rx;

endmodule

// File: rtl/pot_scan_sched.sv
// Round-robin scheduler sharing one ADC128S between the six equalizer pots.
// Define POT_HYST_EN to suppress register updates smaller than HYST LSBs.
module pot_scan_sched
    import eq_pkg::*;
#(
    parameter int SCLK_DIV = 32,
    parameter int GAP_CYC  = 8,
    parameter int HYST     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        A2D_SS_n,
    output logic        A2D_SCLK,
    output logic        A2D_MOSI,
    input  logic        A2D_MISO,
    output logic [11:0] LP_pot,
    output logic [11:0] B1_pot,
    output logic [11:0] B2_pot,
    output logic [11:0] B3_pot,
    output logic [11:0] HP_pot,
    output logic [11:0] volume,
    output logic [5:0]  pot_vld,
    output logic        pot_upd,
    output logic        scan_done
);

`ifdef POT_HYST_EN
    localparam bit HYST_EN = 1'b1;
`else
    localparam bit HYST_EN = 1'b0;
`endif

    localparam int GW = $clog2(GAP_CYC + 1);

    state_e            r_state;
    state_e            w_nxt_state;
    slot_e             r_slot;
    logic [GW-1:0]     r_gap;
    logic [POT_W-1:0]  r_pot [N_SLOT];
    logic [N_SLOT-1:0] r_vld;
    logic              r_upd;
    logic              r_scan;
    logic              w_wrt;
    logic              w_spi_done;
    logic              w_gap1_end;
    logic              w_gap2_end;
    logic              w_wr;
    logic              w_chg;
    logic [15:0]       w_cmd;
    logic [15:0]       w_rd;
    logic [POT_W-1:0]  w_new;
    logic [POT_W-1:0]  w_old;
    logic              w_unused_rd;

    function automatic logic [POT_W-1:0] abs_diff(input logic [POT_W-1:0] a,
                                                  input logic [POT_W-1:0] b);
        return (a > b) ? a - b : b - a;
    endfunction

    // The STORE cycle counts toward the post-read gap, so a slot is exactly
    // two transactions plus two GAP_CYC gaps.
    assign w_gap1_end  = (r_gap == GW'(GAP_CYC - 1));
    assign w_gap2_end  = (r_gap == GW'(GAP_CYC - 2));
    assign w_new       = w_rd[POT_W-1:0];
    assign w_old       = r_pot[r_slot];
    assign w_unused_rd = ^w_rd[15:POT_W];
    assign w_wr        = !r_vld[r_slot] || !HYST_EN || (abs_diff(w_new, w_old) >= POT_W'(HYST));
    assign w_chg       = w_wr && (w_new != w_old);

    spi_mstr16 #(.SCLK_DIV(SCLK_DIV)) u_spi (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wrt     (w_wrt),
        .i_cmd     (w_cmd),
        .i_miso    (A2D_MISO),
        .o_ss_n    (A2D_SS_n),
        .o_sclk    (A2D_SCLK),
        .o_mosi    (A2D_MOSI),
        .o_done    (w_spi_done),
        .o_rd_data (w_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_gap   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_gap   <= (r_state != w_nxt_state) ? '0 : r_gap + 1'b1;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            ST_IDLE:      w_nxt_state = ST_CMD_XFER;
            ST_CMD_XFER:  if (w_spi_done) w_nxt_state = ST_GAP1;
            ST_GAP1:      if (w_gap1_end) w_nxt_state = ST_READ_XFER;
            ST_READ_XFER: if (w_spi_done) w_nxt_state = ST_STORE;
            ST_STORE:     w_nxt_state = ST_GAP2;
            ST_GAP2:      if (w_gap2_end) w_nxt_state = ST_CMD_XFER;
            default:      w_nxt_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cmd = a2d_cmd(CH_MAP[r_slot]);
        w_wrt = (r_state == ST_IDLE)
             || ((r_state == ST_GAP1) && w_gap1_end)
             || ((r_state == ST_GAP2) && w_gap2_end);
    end

    // Result capture; pulses are registered so they follow the register write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= SLOT_LP;
            r_vld  <= '0;
            r_upd  <= 1'b0;
            r_scan <= 1'b0;
            for (int i = 0; i < N_SLOT; i++) r_pot[i] <= '0;
        end else begin
            r_upd  <= 1'b0;
            r_scan <= 1'b0;
            if (r_state == ST_STORE) begin
                if (w_wr) r_pot[r_slot] <= w_new;
                r_vld[r_slot] <= 1'b1;
                r_upd         <= w_chg;
                r_scan        <= (r_slot == SLOT_VOL);
                r_slot        <= (r_slot == SLOT_VOL) ? SLOT_LP : slot_e'(r_slot + 3'd1);
            end
        end
    end

    assign LP_pot    = r_pot[SLOT_LP];
    assign B1_pot    = r_pot[SLOT_B1];
    assign B2_pot    = r_pot[SLOT_B2];
    assign B3_pot    = r_pot[SLOT_B3];
    assign HP_pot    = r_pot[SLOT_HP];
    assign volume    = r_pot[SLOT_VOL];
    assign pot_vld   = r_vld;
    assign pot_upd   = r_upd;
    assign scan_done = r_scan;

endmodule

// File: tb/tb_pot_scan_sched.sv
// Directed bench for pot_scan_sched with a behavioural ADC128S on the SPI pins.
module tb_pot_scan_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        a2d_ss_n, a2d_sclk, a2d_mosi;
    logic        a2d_miso = 1'b0;
    logic [11:0] lp_pot, b1_pot, b2_pot, b3_pot, hp_pot, vol_pot;
    logic [5:0]  pot_vld;
    logic        pot_upd, scan_done;

    always #5 clk = ~clk;

    pot_scan_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A2D_SS_n  (a2d_ss_n),
        .A2D_SCLK  (a2d_sclk),
        .A2D_MOSI  (a2d_mosi),
        .A2D_MISO  (a2d_miso),
        .LP_pot    (lp_pot),
        .B1_pot    (b1_pot),
        .B2_pot    (b2_pot),
        .B3_pot    (b3_pot),
        .HP_pot    (hp_pot),
        .volume    (vol_pot),
        .pot_vld   (pot_vld),
        .pot_upd   (pot_upd),
        .scan_done (scan_done)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ADC128S model: answers each frame with the channel addressed in the previous full frame
    logic [11:0] ch_val [8];
    logic [15:0] adc_tx, adc_rx;
    logic [2:0]  adc_prev_ch = 3'd0;
    logic [2:0]  ch_log [$];
    int adc_bits = 0, adc_falls = 0, last_falls = 0, ssn_falls = 0;
    int cyc = 0, last_fall_cyc = 0, per_min = 1000000, per_max = 0;
    int hi_run = 0, min_hi = 1000000, upd_cnt = 0;
    bit seen_low = 1'b0;

    always @(negedge a2d_ss_n) begin
        adc_tx = {4'h0, ch_val[adc_prev_ch]};
        adc_bits = 0;
        adc_falls = 0;
        ssn_falls++;
    end

    always @(negedge a2d_sclk) begin
        if (!a2d_ss_n) begin
            if (adc_falls > 0) begin
                if (cyc - last_fall_cyc < per_min) per_min = cyc - last_fall_cyc;
                if (cyc - last_fall_cyc > per_max) per_max = cyc - last_fall_cyc;
            end
            last_fall_cyc = cyc;
            adc_falls++;
            a2d_miso = adc_tx[15];
            adc_tx = {adc_tx[14:0], 1'b0};
        end
    end

    always @(posedge a2d_sclk) begin
        if (!a2d_ss_n) begin
            adc_rx = {adc_rx[14:0], a2d_mosi};
            adc_bits++;
        end
    end

    always @(posedge a2d_ss_n) begin
        last_falls = adc_falls;
        if (adc_bits == 16) begin
            adc_prev_ch = adc_rx[13:11];
            ch_log.push_back(adc_rx[13:11]);
        end
    end

    always @(posedge clk) begin
        cyc++;
        if (pot_upd) upd_cnt++;
        if (a2d_ss_n) hi_run++;
        else begin
            if (seen_low && hi_run > 0 && hi_run < min_hi) min_hi = hi_run;
            hi_run = 0;
            seen_low = 1'b1;
        end
    end

    function automatic bit ev_hit(input int sel, input int arg);
        case (sel)
            0:       return !a2d_ss_n;
            1:       return pot_vld[0];
            2:       return scan_done;
            default: return ssn_falls >= arg;
        endcase
    endfunction

    task automatic wait_ev(input int sel, input int arg, input int budget, input string tag);
        int n = 0;
        @(negedge clk);
        while (!ev_hit(sel, arg) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!ev_hit(sel, arg)) chk_vec({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk_vec({tag, "_ss_n"}, 32'(a2d_ss_n), 32'd1);
        chk_vec({tag, "_sclk"}, 32'(a2d_sclk), 32'd1);
        chk_vec({tag, "_mosi"}, 32'(a2d_mosi), 32'd0);
        chk_vec({tag, "_vld"}, 32'(pot_vld), 32'd0);
        chk_vec({tag, "_upd"}, 32'(pot_upd), 32'd0);
        chk_vec({tag, "_scan"}, 32'(scan_done), 32'd0);
        chk_vec({tag, "_lp"}, 32'(lp_pot), 32'd0);
        chk_vec({tag, "_b2"}, 32'(b2_pot), 32'd0);
        chk_vec({tag, "_vol"}, 32'(vol_pot), 32'd0);
    endtask

    initial begin
        int t0, t1, u0, f0;
        logic [17:0] seq_cmd, seq_rd;

        for (int i = 0; i < 8; i++) ch_val[i] = 12'h000;
        ch_val[1] = 12'hABC;
        ch_val[0] = 12'h222;
        ch_val[4] = 12'h333;
        ch_val[2] = 12'h444;
        ch_val[3] = 12'h555;
        ch_val[7] = 12'h666;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outs("rst");

        rst_n = 1'b1;
        t1 = cyc;
        wait_ev(0, 0, 10, "first_ss_fall");
        t0 = cyc;
        chk_vec("ss_fall_after_rst", 32'(t0 - t1), 32'd1);

        // STORE state begins 1096 cycles after SS_n fall; the register shows one edge later
        wait_ev(1, 0, 1200, "lp_store");
        chk_vec("lp_latency", 32'(cyc - t0), 32'd1097);
        chk_vec("lp_value", 32'(lp_pot), 32'hABC);
        chk_vec("lp_vld", 32'(pot_vld), 32'h01);
        chk_vec("lp_upd_on", 32'(pot_upd), 32'd1);
        @(negedge clk);
        chk_vec("lp_upd_off", 32'(pot_upd), 32'd0);

        wait_ev(2, 0, 7000, "scan1");
        t0 = cyc;
        chk_vec("scan1_b1", 32'(b1_pot), 32'h222);
        chk_vec("scan1_b2", 32'(b2_pot), 32'h333);
        chk_vec("scan1_b3", 32'(b3_pot), 32'h444);
        chk_vec("scan1_hp", 32'(hp_pot), 32'h555);
        chk_vec("scan1_vol", 32'(vol_pot), 32'h666);
        chk_vec("scan1_vld", 32'(pot_vld), 32'h3F);
        @(negedge clk);
        chk_vec("scan_done_width", 32'(scan_done), 32'd0);
        chk_vec("scan1_upd_count", 32'(upd_cnt), 32'd6);
        seq_cmd = '0;
        seq_rd  = '0;
        for (int i = 0; i < 6; i++) begin
            seq_cmd = {seq_cmd[14:0], ch_log[2*i]};
            seq_rd  = {seq_rd[14:0], ch_log[2*i+1]};
        end
        chk_vec("cmd_chan_order", 32'(seq_cmd), 32'(18'o104237));
        chk_vec("read_chan_order", 32'(seq_rd), 32'(18'o104237));

        u0 = upd_cnt;
        wait_ev(2, 0, 7000, "scan2");
        chk_vec("scan_period_2", 32'(cyc - t0), 32'd6624);
        t0 = cyc;
        wait_ev(2, 0, 7000, "scan3");
        chk_vec("scan_period_3", 32'(cyc - t0), 32'd6624);
        @(negedge clk);
        chk_vec("steady_no_upd", 32'(upd_cnt - u0), 32'd0);

        chk_vec("sclk_period_min", 32'(per_min), 32'd32);
        chk_vec("sclk_period_max", 32'(per_max), 32'd32);
        chk_vec("falls_per_frame", 32'(last_falls), 32'd16);
        chk_vec("ss_hi_ge_gap", 32'(min_hi >= 8), 32'd1);

        // Sixth SS_n fall after scan_done is the READ frame of B2
        f0 = ssn_falls;
        wait_ev(3, f0 + 6, 7000, "b2_read");
        repeat (100) @(negedge clk);
        chk_vec("b2_read_active", 32'(a2d_ss_n), 32'd0);
        ch_val[4] = 12'hDDD;
        #2 rst_n = 1'b0;
        #1 chk_vec("async_ss_n", 32'(a2d_ss_n), 32'd1);
        @(negedge clk);
        chk_reset_outs("midrst");
        @(negedge clk);
        ch_log.delete();
        ch_val[7] = 12'h800;
        rst_n = 1'b1;
        wait_ev(1, 0, 1200, "restart_lp");
        chk_vec("restart_vld", 32'(pot_vld), 32'h01);
        chk_vec("restart_lp", 32'(lp_pot), 32'hABC);
        chk_vec("restart_first_ch", 32'(ch_log[0]), 32'd1);

        wait_ev(2, 0, 7000, "scan_r1");
        @(negedge clk);
        chk_vec("vol_800", 32'(vol_pot), 32'h800);
        chk_vec("b2_after_rst", 32'(b2_pot), 32'hDDD);

        ch_val[7] = 12'h802;
        u0 = upd_cnt;
        wait_ev(2, 0, 7000, "scan_r2");
        @(negedge clk);
`ifdef POT_HYST_EN
        chk_vec("vol_small_step", 32'(vol_pot), 32'h800);
        chk_vec("vol_small_upd", 32'(upd_cnt - u0), 32'd0);
`else
        chk_vec("vol_small_step", 32'(vol_pot), 32'h802);
        chk_vec("vol_small_upd", 32'(upd_cnt - u0), 32'd1);
`endif

        ch_val[7] = 12'h805;
        u0 = upd_cnt;
        wait_ev(2, 0, 7000, "scan_r3");
        @(negedge clk);
        chk_vec("vol_805", 32'(vol_pot), 32'h805);
        chk_vec("vol_805_upd", 32'(upd_cnt - u0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pot_scan_sched.md
# pot_scan_sched

Round-robin scheduler that shares the single ADC128S SPI A2D between the six equalizer slide pots (LP, B1, B2, B3, HP, volume). It sequences two-transaction conversions per channel, captures the 12-bit results into per-pot registers, and flags updates to the filter-gain and volume logic inside the Equalizer top level. It sits between the A2D pins (A2D_SS_n/SCLK/MOSI/MISO) and the band-gain datapath.

## Interface
- SCLK_DIV, 32: clk cycles per SPI SCLK period (even, ≥4)
- GAP_CYC, 8: SS_n-high cycles between transactions
- HYST, 4: update threshold in LSBs (used only with POT_HYST_EN)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- A2D_SS_n  out  1  SPI slave select, active low
- A2D_SCLK  out  1  SPI clock, idles high
- A2D_MOSI  out  1  SPI data to A2D
- A2D_MISO  in  1  SPI data from A2D
- LP_pot, B1_pot, B2_pot, B3_pot, HP_pot, volume  out  12 each  latest conversion per pot
- pot_vld  out  6  bit i set after first capture of pot i (order LP,B1,B2,B3,HP,vol = bits 0..5)
- pot_upd  out  1  one-cycle pulse when any pot register changes
- scan_done  out  1  one-cycle pulse after volume (last slot) is stored

## Operation
- Fixed slot order LP→B1→B2→B3→HP→volume→LP…; A2D channel map: LP=1, B1=0, B2=4, B3=2, HP=3, volume=7.
- Per slot, two 16-bit transactions: CMD (MOSI word = {2'b00, ch[2:0], 11'b0}), then READ (MOSI word same as CMD); result = MISO word[11:0] of READ.
- FSM: IDLE → CMD_XFER → GAP1 → READ_XFER → STORE → GAP2 → CMD_XFER (next slot). IDLE left one cycle after reset deassert.
- STORE: write result into slot register, set pot_vld bit, pulse pot_upd if value differs from old; on volume slot pulse scan_done; advance slot index, wrap 5→0.
- Reset mid-transaction: SS_n forced high immediately, slot index returns to LP, all registers cleared; no partial result ever stored.
- MISO value is ignored during CMD_XFER.

## Timing
- Reset values: A2D_SS_n=1, A2D_SCLK=1, A2D_MOSI=0, all pot registers 0, pot_vld=0, pot_upd=0, scan_done=0.
- SS_n falls SCLK_DIV/2 cycles before first SCLK fall; MOSI changes on SCLK fall, MISO sampled on SCLK rise (MSB first); SS_n rises SCLK_DIV/2 cycles after 16th rise.
- One transaction = 16·SCLK_DIV + SCLK_DIV cycles (544 at default); GAP_CYC between transactions.
- Slot latency (CMD SS_n fall → STORE) = 2·544 + 8 cycles = 1096 at defaults; full scan = 6 slots incl. GAP2 = 6624 cycles.
- Pot register and pot_vld update on the same clk edge; pot_upd/scan_done asserted exactly that following cycle, one cycle wide.

## Configuration
- POT_HYST_EN defined: STORE writes only if |new − old| ≥ HYST or pot_vld bit is clear; otherwise register and pot_upd unchanged (pot_vld still set, scan_done still pulses).
- Undefined: every STORE writes the result; pot_upd pulses on any change.

## Structure
- Shared package eq_pkg: slot enum (SLOT_LP..SLOT_VOL), channel-map constant array, FSM state typedef, pot width constant (12).
- Sub-module spi_mstr16: 16-bit full-duplex SPI master (wrt pulse, cmd[15:0] in; done pulse, rd_data[15:0] out), parameterized by SCLK_DIV; scheduler FSM instantiates it once.

## Test plan
- Reset then release with ADC128S model returning ch1=0xABC: first STORE at cycle ~1096 → LP_pot=0xABC, pot_vld=6'b000001, one pot_upd pulse.
- Model returns distinct values 0x111·(slot+1) per channel → after one scan all six registers match, pot_vld=6'h3F, exactly one scan_done pulse, MOSI channel fields seen in order 1,0,4,2,3,7.
- Hold all channels constant for 3 scans → no pot_upd after first scan, scan_done every 6624 cycles.
- Assert rst_n low mid READ_XFER of B2 → SS_n high within same cycle, all outputs reset values, next scan restarts at LP.
- With POT_HYST_EN, HYST=4: volume 0x800 → 0x802 leaves volume=0x800, no pot_upd; → 0x805 updates to 0x805 with pot_upd.
- Check SPI timing: SCLK period 32 cycles, 16 falls per SS_n-low window, SS_n high ≥ GAP_CYC between transactions.
